control_unit_p: RTL and testbench
=================================

// Module: control_unit_p
// PURPOSE
//  Parametrised successor to the nopCPU control unit: fetch/decode/sequence FSM driving ALU, register file, PC and user memory.
//  Adds configurable data/address width, a bounded hardware stack window in user memory, and a maskable interrupt with RTI/EI/DI.
//  Sits between program memory/PC and the datapath. Instruction = DATA_W bits: [DATA_W-1 -:4] opcode, then ra and rb fields (RSEL_W bits each) in the low bits.
// PARAMETERS
//  DATA_W       8      datapath/instruction width; must be >= 4+2*RSEL_W
//  ADDR_W       8      program and user memory address width
//  RSEL_W       2      register-select width (2**RSEL_W registers)
//  STACK_BASE   8'hC0  user-memory address of stack entry 0
//  STACK_DEPTH  32     max stack entries; SP range 0..STACK_DEPTH
//  RESET_VEC    0      PC target after reset
//  IRQ_VEC      8'hFD  PC target on interrupt entry
// PORTS
//  clk         in   1       clock, all state on rising edge
//  reset_n     in   1       asynchronous active-low reset
//  irq         in   1       level interrupt request
//  imem_data   in   DATA_W  instruction/operand at current PC
//  imem_addr   in   ADDR_W  current PC value
//  rf_out1     in   DATA_W  register file port 1 (ra)
//  rf_out2     in   DATA_W  register file port 2 (rb)
//  alu_out     in   DATA_W  ALU result
//  umem_rdata  in   DATA_W  user memory read data, valid the cycle after umem_addr changes
//  alu_op      out  4       opcode field, combinational
//  rf_rd1      out  RSEL_W  read select 1: ra of imem_data in FETCH, of latched instr otherwise
//  rf_rd2      out  RSEL_W  read select 2: same rule, rb field
//  rf_wsel     out  RSEL_W  write select = rb of latched instr
//  rf_we       out  1       register write enable (registered)
//  rf_data     out  DATA_W  register write data (registered)
//  umem_addr   out  ADDR_W  user memory address (registered)
//  umem_wdata  out  DATA_W  user memory write data (registered)
//  umem_we     out  1       user memory write strobe, one cycle per write
//  pc_jump     out  1       load PC from pc_jmpaddr
//  pc_jmpaddr  out  ADDR_W  jump target
//  pc_freeze   out  1       hold PC; high in RET_WAIT, LOAD_WAIT, POP_WAIT
//  stk_fault   out  1       sticky stack over/underflow flag
// BEHAVIOUR
//  Reset (async): all registered outputs 0 except pc_jump=1, pc_jmpaddr=RESET_VEC; SP=0, IE=0, state=REFILL, stk_fault=0.
//  States: FETCH, OPERAND, REFILL, SKIP, RET_WAIT, LOAD_WAIT, POP_WAIT.
//  FETCH: if irq&IE -> push imem_addr, IE<=0, jump IRQ_VEC, ->REFILL (current instr not executed). Otherwise latch instr, decode:
//   0-7 ALU: rf_we=1, rf_data=alu_out, stay FETCH (1 cycle).   8 LD, E ST, F LDUMEM -> OPERAND.
//   9 JMP: jump rf_out2 ->REFILL.   A CALL: push imem_addr+1, jump rf_out2 ->REFILL.
//   B sub 0 RTS / 3 RTI: pop ->RET_WAIT (RTI also IE<=1).  1 STSP: rf_data=SP (zero-ext/trunc).
//   B sub 2 POP ->POP_WAIT.  4 LDSP: SP<=rf_out1 (trunc).  8 PUSH rf_out1.  5 EI / 6 DI: IE<=1/0.  Other subcodes: NOP.
//   C IEQ / D INE: rf_out1==rf_out2 (resp. !=) -> SKIP, else FETCH.
//  OPERAND (imem_data=operand): LD rf<=operand; ST umem[operand]<=rf_out1; LDUMEM umem_addr<=operand ->LOAD_WAIT.
//  REFILL: pc_jump<=0, ->FETCH.  SKIP: skipped opcode 8/E/F (2-word) -> REFILL-style extra cycle, else ->FETCH.
//  RET_WAIT: pc_jmpaddr<=umem_rdata, pc_jump<=1 ->REFILL.  LOAD_WAIT/POP_WAIT: rf_we=1, rf_data<=umem_rdata ->FETCH.
//  rf_we and umem_we drop to 0 in every state not asserting them. IRQ is sampled only in FETCH; never mid-instruction.
//  Stack: push writes STACK_BASE+SP then SP+1; pop SP-1 then reads STACK_BASE+SP-1. Empty SP=0, full SP=STACK_DEPTH.
//  Latency: ALU/STSP/LDSP/PUSH/EI/DI 1 cycle; LD/ST 2; LDUMEM/POP 3; JMP 2; CALL 2; RTS/RTI 3.
// CONFIGURATION
//  NOPCPU_STACK_GUARD_EN defined: push at SP==STACK_DEPTH or pop at SP==0 is suppressed (no write, SP unchanged, RTS/RTI/POP treated as NOP ->FETCH), stk_fault<=1 until reset.
//  Not defined: SP wraps modulo STACK_DEPTH+1, no suppression, stk_fault tied 0.
// TESTING
//  reset_n low mid-LDUMEM -> outputs at reset values immediately; after release pc_jump=1, pc_jmpaddr=0 one cycle, then FETCH.
//  LD r1,#8'h5A; PUSH r1; POP r2 -> umem[C0]=5A written, r2=5A after 3 cycles, SP back to 0.
//  CALL to 8'h40 at PC 8'h10, RTS at 8'h40 -> umem[C0]=8'h11, PC returns to 8'h11, SP=0.
//  EI, irq=1 at FETCH of ALU op at 8'h20 -> op not executed, umem[C0]=8'h20, PC=FD, IE=0; RTI -> PC=8'h20, IE=1; irq with IE=0 ignored.
//  IEQ r0,r1 with r0==r1 followed by LD (2-word) -> both words skipped; with r0!=r1 LD executes.
//  Guard on: POP with SP=0 -> no rf write, SP=0, stk_fault=1 sticky; guard off: SP wraps to STACK_DEPTH, stk_fault=0.

Source files
------------

// File: rtl/control_unit_p_if.sv
// Control-unit bus bundle: instruction fetch, register file, ALU, user memory and PC control.
// master = control unit side, slave = datapath/memory side.
interface control_unit_p_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RSEL_W = 2
);
    logic [DATA_W-1:0] imem_data;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] rf_out1;
    logic [DATA_W-1:0] rf_out2;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] umem_rdata;
    logic [3:0]        alu_op;
    logic [RSEL_W-1:0] rf_rd1;
    logic [RSEL_W-1:0] rf_rd2;
    logic [RSEL_W-1:0] rf_wsel;
    logic              rf_we;
    logic [DATA_W-1:0] rf_data;
    logic [ADDR_W-1:0] umem_addr;
    logic [DATA_W-1:0] umem_wdata;
    logic              umem_we;
    logic              pc_jump;
    logic [ADDR_W-1:0] pc_jmpaddr;
    logic              pc_freeze;
    logic              stk_fault;

    modport master (
        input  imem_data, imem_addr, rf_out1, rf_out2, alu_out, umem_rdata,
        output alu_op, rf_rd1, rf_rd2, rf_wsel, rf_we, rf_data,
               umem_addr, umem_wdata, umem_we, pc_jump, pc_jmpaddr, pc_freeze, stk_fault
    );

    modport slave (
        output imem_data, imem_addr, rf_out1, rf_out2, alu_out, umem_rdata,
        input  alu_op, rf_rd1, rf_rd2, rf_wsel, rf_we, rf_data,
               umem_addr, umem_wdata, umem_we, pc_jump, pc_jmpaddr, pc_freeze, stk_fault
    );
endinterface

// File: rtl/control_unit_p.sv
// Parametrised nopCPU control unit: fetch/decode/sequence FSM with user-memory stack and maskable IRQ.
// Define NOPCPU_STACK_GUARD_EN to suppress stack over/underflow and raise the sticky stk_fault flag.
// Opcode-B subcode is the 4 bits directly below the opcode (overlaps ra/rb when DATA_W == 8).
module control_unit_p #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       RSEL_W      = 2,
    parameter logic [ADDR_W-1:0] STACK_BASE  = ADDR_W'(8'hC0),
    parameter int unsigned       STACK_DEPTH = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter logic [ADDR_W-1:0] IRQ_VEC     = ADDR_W'(8'hFD)
) (
    input logic              clk,
    input logic              reset_n,
    input logic              irq,
    control_unit_p_if.master bus
);
    localparam int unsigned     SP_W   = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH, S_OPERAND, S_REFILL, S_SKIP, S_RET_WAIT, S_LOAD_WAIT, S_POP_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ie_q, ie_d;
    logic              fault_q, fault_d;
    logic              rf_we_q, rf_we_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [ADDR_W-1:0] umem_addr_q, umem_addr_d;
    logic [DATA_W-1:0] umem_wdata_q, umem_wdata_d;
    logic              umem_we_q, umem_we_d;
    logic              pc_jump_q, pc_jump_d;
    logic [ADDR_W-1:0] pc_jmpaddr_q, pc_jmpaddr_d;
    logic              pc_freeze_q, pc_freeze_d;

    logic [DATA_W-1:0] cur_instr;
    logic [3:0]        f_op, f_sub, q_op;
    logic [SP_W-1:0]   sp_inc, sp_dec;
    logic [ADDR_W-1:0] push_addr, pop_addr, ret_addr;
    logic              push_blk, pop_blk;
    logic              push_req;
    logic [DATA_W-1:0] push_data;

    // Register selects follow the incoming word in FETCH, the latched word afterwards
    assign cur_instr   = (state_q == S_FETCH) ? bus.imem_data : instr_q;
    assign bus.alu_op  = cur_instr[DATA_W-1 -: 4];
    assign bus.rf_rd1  = cur_instr[2*RSEL_W-1 -: RSEL_W];
    assign bus.rf_rd2  = cur_instr[RSEL_W-1:0];
    assign bus.rf_wsel = instr_q[RSEL_W-1:0];

    assign f_op  = bus.imem_data[DATA_W-1 -: 4];
    assign f_sub = bus.imem_data[DATA_W-5 -: 4];
    assign q_op  = instr_q[DATA_W-1 -: 4];

    assign sp_inc    = (sp_q == SP_MAX) ? '0 : sp_q + SP_W'(1);
    assign sp_dec    = (sp_q == '0) ? SP_MAX : sp_q - SP_W'(1);
    assign push_addr = STACK_BASE + ADDR_W'(sp_q);
    assign pop_addr  = STACK_BASE + ADDR_W'(sp_dec);
    assign ret_addr  = bus.imem_addr + ADDR_W'(1);

`ifdef NOPCPU_STACK_GUARD_EN
    assign push_blk = (sp_q == SP_MAX);
    assign pop_blk  = (sp_q == '0);
`else
    assign push_blk = 1'b0;
    assign pop_blk  = 1'b0;
`endif

    function automatic logic two_word(input logic [3:0] op);
        return (op == 4'h8) || (op == 4'hE) || (op == 4'hF);
    endfunction

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        sp_d         = sp_q;
        ie_d         = ie_q;
        fault_d      = fault_q;
        rf_we_d      = 1'b0;
        rf_data_d    = rf_data_q;
        umem_addr_d  = umem_addr_q;
        umem_wdata_d = umem_wdata_q;
        umem_we_d    = 1'b0;
        pc_jump_d    = 1'b0;
        pc_jmpaddr_d = pc_jmpaddr_q;
        pc_freeze_d  = 1'b0;
        push_req     = 1'b0;
        push_data    = '0;

        case (state_q)
            S_FETCH: begin
                if (irq && ie_q) begin
                    ie_d         = 1'b0;
                    push_req     = 1'b1;
                    push_data    = DATA_W'(bus.imem_addr);
                    pc_jump_d    = 1'b1;
                    pc_jmpaddr_d = IRQ_VEC;
                    state_d      = S_REFILL;
                end else begin
                    instr_d = bus.imem_data;
                    case (f_op)
                        4'h8, 4'hE, 4'hF: state_d = S_OPERAND;
                        4'h9: begin
                            pc_jump_d    = 1'b1;
                            pc_jmpaddr_d = ADDR_W'(bus.rf_out2);
                            state_d      = S_REFILL;
                        end
                        4'hA: begin
                            push_req     = 1'b1;
                            push_data    = DATA_W'(ret_addr);
                            pc_jump_d    = 1'b1;
                            pc_jmpaddr_d = ADDR_W'(bus.rf_out2);
                            state_d      = S_REFILL;
                        end
                        4'hB: begin
                            case (f_sub)
                                4'h0, 4'h2, 4'h3: begin
                                    if (pop_blk) begin
                                        fault_d = 1'b1;
                                    end else begin
                                        sp_d        = sp_dec;
                                        umem_addr_d = pop_addr;
                                        state_d     = (f_sub == 4'h2) ? S_POP_WAIT : S_RET_WAIT;
                                        if (f_sub == 4'h3) ie_d = 1'b1;
                                    end
                                end
                                4'h1: begin
                                    rf_we_d   = 1'b1;
                                    rf_data_d = DATA_W'(sp_q);
                                end
                                4'h4: sp_d = SP_W'(bus.rf_out1);
                                4'h5: ie_d = 1'b1;
                                4'h6: ie_d = 1'b0;
                                4'h8: begin
                                    push_req  = 1'b1;
                                    push_data = bus.rf_out1;
                                end
                                default: ;
                            endcase
                        end
                        4'hC: if (bus.rf_out1 == bus.rf_out2) state_d = S_SKIP;
                        4'hD: if (bus.rf_out1 != bus.rf_out2) state_d = S_SKIP;
                        default: begin
                            rf_we_d   = 1'b1;
                            rf_data_d = bus.alu_out;
                        end
                    endcase
                end
            end
            S_OPERAND: begin
                state_d = S_FETCH;
                case (q_op)
                    4'h8: begin
                        rf_we_d   = 1'b1;
                        rf_data_d = bus.imem_data;
                    end
                    4'hE: begin
                        umem_addr_d  = ADDR_W'(bus.imem_data);
                        umem_wdata_d = bus.rf_out1;
                        umem_we_d    = 1'b1;
                    end
                    default: begin
                        umem_addr_d = ADDR_W'(bus.imem_data);
                        state_d     = S_LOAD_WAIT;
                    end
                endcase
            end
            // Skipping a two-word instruction burns one more cycle to step over its operand
            S_SKIP:   state_d = two_word(f_op) ? S_REFILL : S_FETCH;
            S_REFILL: state_d = S_FETCH;
            S_RET_WAIT: begin
                pc_jump_d    = 1'b1;
                pc_jmpaddr_d = ADDR_W'(bus.umem_rdata);
                state_d      = S_REFILL;
            end
            S_LOAD_WAIT, S_POP_WAIT: begin
                rf_we_d   = 1'b1;
                rf_data_d = bus.umem_rdata;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (push_req) begin
            if (push_blk) begin
                fault_d = 1'b1;
            end else begin
                umem_addr_d  = push_addr;
                umem_wdata_d = push_data;
                umem_we_d    = 1'b1;
                sp_d         = sp_inc;
            end
        end

        pc_freeze_d = (state_d == S_RET_WAIT) || (state_d == S_LOAD_WAIT) ||
                      (state_d == S_POP_WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_REFILL;
            instr_q      <= '0;
            sp_q         <= '0;
            ie_q         <= 1'b0;
            fault_q      <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_data_q    <= '0;
            umem_addr_q  <= '0;
            umem_wdata_q <= '0;
            umem_we_q    <= 1'b0;
            pc_jump_q    <= 1'b1;
            pc_jmpaddr_q <= RESET_VEC;
            pc_freeze_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            sp_q         <= sp_d;
            ie_q         <= ie_d;
            fault_q      <= fault_d;
            rf_we_q      <= rf_we_d;
            rf_data_q    <= rf_data_d;
            umem_addr_q  <= umem_addr_d;
            umem_wdata_q <= umem_wdata_d;
            umem_we_q    <= umem_we_d;
            pc_jump_q    <= pc_jump_d;
            pc_jmpaddr_q <= pc_jmpaddr_d;
            pc_freeze_q  <= pc_freeze_d;
        end
    end

    assign bus.rf_we      = rf_we_q;
    assign bus.rf_data    = rf_data_q;
    assign bus.umem_addr  = umem_addr_q;
    assign bus.umem_wdata = umem_wdata_q;
    assign bus.umem_we    = umem_we_q;
    assign bus.pc_jump    = pc_jump_q;
    assign bus.pc_jmpaddr = pc_jmpaddr_q;
    assign bus.pc_freeze  = pc_freeze_q;
    assign bus.stk_fault  = fault_q;
endmodule

// File: tb/tb_control_unit_p.sv
// Directed bench for control_unit_p: surrounds the unit with a PC, program ROM, write-through
// register file, ALU and user memory, then runs short programs with hand-computed expectations.
module tb_control_unit_p;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic irq = 1'b0;

    always #5 clk = ~clk;

    control_unit_p_if #(.DATA_W(8), .ADDR_W(8), .RSEL_W(2)) bus ();

    control_unit_p dut (
        .clk    (clk),
        .reset_n(reset_n),
        .irq    (irq),
        .bus    (bus)
    );

    logic [7:0] prog      [256];
    logic [7:0] umem      [256];
    logic [7:0] umem_init [256];
    logic [7:0] regs      [4];
    logic [7:0] regs_init [4];
    logic [7:0] pc;
    logic [7:0] alu_res;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment: PC, memories and register file; reset reloads the preset contents
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc   <= 8'h77;
            umem <= umem_init;
            regs <= regs_init;
        end else begin
            if (bus.umem_we) umem[bus.umem_addr] <= bus.umem_wdata;
            if (bus.rf_we) regs[bus.rf_wsel] <= bus.rf_data;
            if (bus.pc_jump) pc <= bus.pc_jmpaddr;
            else if (!bus.pc_freeze) pc <= pc + 8'd1;
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.imem_data  = prog[pc];
    assign bus.umem_rdata = umem[bus.umem_addr];
    assign bus.rf_out1 = (bus.rf_we && bus.rf_wsel == bus.rf_rd1) ? bus.rf_data : regs[bus.rf_rd1];
    assign bus.rf_out2 = (bus.rf_we && bus.rf_wsel == bus.rf_rd2) ? bus.rf_data : regs[bus.rf_rd2];
    assign bus.alu_out = alu_res;

    always_comb begin
        case (bus.alu_op)
            4'h0:    alu_res = bus.rf_out1 + bus.rf_out2;
            4'h1:    alu_res = bus.rf_out1 - bus.rf_out2;
            4'h2:    alu_res = bus.rf_out1 & bus.rf_out2;
            4'h3:    alu_res = bus.rf_out1 | bus.rf_out2;
            4'h4:    alu_res = bus.rf_out1 ^ bus.rf_out2;
            4'h5:    alu_res = bus.rf_out1;
            4'h6:    alu_res = bus.rf_out2;
            4'h7:    alu_res = ~bus.rf_out1;
            default: alu_res = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear();
        for (int i = 0; i < 256; i++) begin
            prog[i]      = 8'hB7;
            umem_init[i] = 8'h00;
        end
        for (int i = 0; i < 4; i++) regs_init[i] = 8'h00;
    endtask

    // Hold reset two cycles, release on a falling edge
    task automatic boot();
        reset_n = 1'b0;
        irq     = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset values, then reset in the middle of LDUMEM r1,[30]
        clear();
        prog[8'h00] = 8'hF1; prog[8'h01] = 8'h30; umem_init[8'h30] = 8'h99;
        reset_n = 1'b0;
        cyc(2);
        check("rst_pc_jump", 32'(bus.pc_jump), 32'd1);
        check("rst_jmpaddr", 32'(bus.pc_jmpaddr), 32'h00);
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_umem_we", 32'(bus.umem_we), 32'd0);
        check("rst_umem_addr", 32'(bus.umem_addr), 32'h00);
        check("rst_freeze", 32'(bus.pc_freeze), 32'd0);
        check("rst_stk_fault", 32'(bus.stk_fault), 32'd0);
        reset_n = 1'b1;
        cyc(1);
        check("boot_pc", 32'(pc), 32'h00);
        check("boot_jump_drop", 32'(bus.pc_jump), 32'd0);
        cyc(2);
        check("ldu_addr", 32'(bus.umem_addr), 32'h30);
        check("ldu_freeze", 32'(bus.pc_freeze), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_addr", 32'(bus.umem_addr), 32'h00);
        check("midrst_freeze", 32'(bus.pc_freeze), 32'd0);
        check("midrst_jump", 32'(bus.pc_jump), 32'd1);
        boot();
        cyc(4);
        check("ldu_rf_we", 32'(bus.rf_we), 32'd1);
        check("ldu_rf_data", 32'(bus.rf_data), 32'h99);
        check("ldu_pc", 32'(pc), 32'h02);
        cyc(1);
        check("ldu_r1", 32'(regs[1]), 32'h99);

        // LD r2,#5A; PUSH r2; LD r2,#00; POP r2; STSP r1
        clear();
        prog[0] = 8'h82; prog[1] = 8'h5A; prog[2] = 8'hB8; prog[3] = 8'h82;
        prog[4] = 8'h00; prog[5] = 8'hB2; prog[6] = 8'hB1;
        regs_init[1] = 8'hFF;
        boot();
        cyc(5);
        check("push_mem", 32'(umem[8'hC0]), 32'h5A);
        cyc(2);
        check("pop_r2_cleared", 32'(regs[2]), 32'h00);
        check("pop_freeze", 32'(bus.pc_freeze), 32'd1);
        check("pop_addr", 32'(bus.umem_addr), 32'hC0);
        cyc(1);
        check("pop_rf_data", 32'(bus.rf_data), 32'h5A);
        check("pop_pc", 32'(pc), 32'h06);
        cyc(1);
        check("pop_r2", 32'(regs[2]), 32'h5A);
        cyc(1);
        check("pop_sp", 32'(regs[1]), 32'h00);

        // JMP 10; CALL 40 at 10; RTS at 40; STSP at 11
        clear();
        prog[8'h00] = 8'h91; prog[8'h10] = 8'hA3; prog[8'h11] = 8'hB1; prog[8'h40] = 8'hB0;
        regs_init[1] = 8'h10; regs_init[3] = 8'h40;
        boot();
        cyc(3);
        check("jmp_pc", 32'(pc), 32'h10);
        cyc(2);
        check("call_pc", 32'(pc), 32'h40);
        check("call_ret_mem", 32'(umem[8'hC0]), 32'h11);
        cyc(1);
        check("rts_freeze", 32'(bus.pc_freeze), 32'd1);
        cyc(1);
        check("rts_jump", 32'(bus.pc_jump), 32'd1);
        check("rts_jmpaddr", 32'(bus.pc_jmpaddr), 32'h11);
        cyc(1);
        check("rts_pc", 32'(pc), 32'h11);
        cyc(2);
        check("rts_sp", 32'(regs[1]), 32'h00);

        // EI; JMP 20; irq at ADD r0,r1 (20); RTI at FD
        clear();
        prog[8'h00] = 8'hB5; prog[8'h01] = 8'h91; prog[8'h20] = 8'h01; prog[8'hFD] = 8'hB3;
        regs_init[0] = 8'h03; regs_init[1] = 8'h20;
        boot();
        cyc(4);
        check("irq_pre_pc", 32'(pc), 32'h20);
        irq = 1'b1;
        cyc(2);
        check("irq_vec_pc", 32'(pc), 32'hFD);
        check("irq_saved_pc", 32'(umem[8'hC0]), 32'h20);
        check("irq_op_skipped", 32'(regs[1]), 32'h20);
        cyc(1);
        check("irq_masked_jump", 32'(bus.pc_jump), 32'd0);
        check("irq_masked_pc", 32'(pc), 32'hFE);
        check("rti_freeze", 32'(bus.pc_freeze), 32'd1);
        cyc(2);
        check("rti_pc", 32'(pc), 32'h20);
        cyc(1);
        check("reirq_jump", 32'(bus.pc_jump), 32'd1);
        check("reirq_vec", 32'(bus.pc_jmpaddr), 32'hFD);
        check("reirq_push", 32'(bus.umem_wdata), 32'h20);
        irq = 1'b0;
        cyc(6);
        check("alu_after_rti", 32'(regs[1]), 32'h23);

        // IEQ r0,r1 equal: skip two-word LD r2,#77
        clear();
        prog[0] = 8'hC1; prog[1] = 8'h82; prog[2] = 8'h77;
        regs_init[0] = 8'h05; regs_init[1] = 8'h05; regs_init[2] = 8'hEE; regs_init[3] = 8'hCC;
        boot();
        cyc(4);
        check("ieq_skip_pc", 32'(pc), 32'h03);
        cyc(2);
        check("ieq_skip_r2", 32'(regs[2]), 32'hEE);
        check("ieq_skip_r3", 32'(regs[3]), 32'hCC);

        // IEQ not equal: LD executes
        regs_init[1] = 8'h06;
        boot();
        cyc(4);
        check("ieq_ne_pc", 32'(pc), 32'h03);
        check("ieq_ne_data", 32'(bus.rf_data), 32'h77);
        cyc(1);
        check("ieq_ne_r2", 32'(regs[2]), 32'h77);

        // INE r0,r1 not equal: skip one-word NOT r1->r3
        prog[0] = 8'hD1; prog[1] = 8'h77; prog[2] = 8'hB7;
        boot();
        cyc(3);
        check("ine_skip_pc", 32'(pc), 32'h02);
        cyc(3);
        check("ine_skip_r3", 32'(regs[3]), 32'hCC);

        // POP r2 on empty stack, then STSP r1
        clear();
        prog[0] = 8'hB2; prog[1] = 8'hB1;
        regs_init[1] = 8'hFF; regs_init[2] = 8'hEE; umem_init[8'hE0] = 8'h3C;
        boot();
        cyc(2);
`ifdef NOPCPU_STACK_GUARD_EN
        check("guard_fault", 32'(bus.stk_fault), 32'd1);
        check("guard_freeze", 32'(bus.pc_freeze), 32'd0);
        check("guard_pc", 32'(pc), 32'h01);
        cyc(2);
        check("guard_sp", 32'(regs[1]), 32'h00);
        check("guard_r2", 32'(regs[2]), 32'hEE);
        cyc(3);
        check("guard_sticky", 32'(bus.stk_fault), 32'd1);
`else
        check("wrap_addr", 32'(bus.umem_addr), 32'hE0);
        check("wrap_freeze", 32'(bus.pc_freeze), 32'd1);
        check("wrap_fault", 32'(bus.stk_fault), 32'd0);
        cyc(1);
        check("wrap_data", 32'(bus.rf_data), 32'h3C);
        cyc(2);
        check("wrap_r2", 32'(regs[2]), 32'h3C);
        check("wrap_sp", 32'(regs[1]), 32'h20);
        check("wrap_fault_end", 32'(bus.stk_fault), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
